// File: rtl/gpio_in_conditioner_if.sv
// Pin bundle between the raw board inputs and the conditioned PIO word.
// The master drives the raw inputs and the clears; the slave is the conditioner.
interface gpio_in_conditioner_if;
  logic [3:0]  key_i;
  logic [9:0]  sw_i;
  logic [3:0]  flag_clr_i;
  logic [31:0] gpio_in_o;
  logic        press_pending_o;

  modport master (
    output key_i, sw_i, flag_clr_i,
    input  gpio_in_o, press_pending_o
  );

  modport slave (
    input  key_i, sw_i, flag_clr_i,
    output gpio_in_o, press_pending_o
  );
endinterface

// File: rtl/gpio_in_conditioner.sv
// Synchronizes, debounces and packs 4 keys and 10 switches into a 32-bit PIO word.
// Define GPIO_IN_CONDITIONER_EDGE_CAPTURE_EN to build the sticky key-press flags.
module gpio_in_conditioner #(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic           CLK_50,
  input  logic           reset_n,
  gpio_in_conditioner_if.slave bus
);

  localparam int NBITS = 14;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW    = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
  // Keys idle high (active-low buttons), switches idle low.
  localparam logic [NBITS-1:0] RST_VAL   = 14'h000F;

  logic [NBITS-1:0] r_meta;
  logic [NBITS-1:0] r_sync;
  logic [TW-1:0]    r_tickCnt;
  logic             w_tick;
  logic [NBITS-1:0] r_stable;
  logic [NBITS-1:0] w_stableNext;
  logic [CW-1:0]    r_cnt      [NBITS];
  logic [CW-1:0]    w_cntNext  [NBITS];

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= {bus.sw_i, bus.key_i};
      r_sync <= r_meta;
    end
  end

  assign w_tick = (r_tickCnt == TICK_LAST);

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_tickCnt <= '0;
    end else if (w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 1'b1;
    end
  end

  // A bit is accepted only after DEBOUNCE_TICKS consecutive ticks disagree with it.
  always_comb begin
    w_stableNext = r_stable;
    for (int i = 0; i < NBITS; i++) begin
      w_cntNext[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync[i] == r_stable[i]) begin
          w_cntNext[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_stableNext[i] = r_sync[i];
          w_cntNext[i]    = '0;
        end else begin
          w_cntNext[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= RST_VAL;
      for (int i = 0; i < NBITS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stableNext;
      r_cnt    <= w_cntNext;
    end
  end

`ifdef GPIO_IN_CONDITIONER_EDGE_CAPTURE_EN
  logic [3:0] w_press;
  logic [3:0] w_flagsNext;
  logic [3:0] r_flags;
  logic       r_pending;

  // Press is the 1->0 transition of a stable key; a coincident clear loses to it.
  assign w_press     = r_stable[3:0] & ~w_stableNext[3:0];
  assign w_flagsNext = (r_flags & ~bus.flag_clr_i) | w_press;

  always_ff @(posedge CLK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_flags   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_flags   <= w_flagsNext;
      r_pending <= |w_flagsNext;
    end
  end

  assign bus.gpio_in_o       = {14'b0, r_flags, r_stable};
  assign bus.press_pending_o = r_pending;
`else
  logic w_unusedClr;

  assign w_unusedClr         = &{1'b0, bus.flag_clr_i};
  assign bus.gpio_in_o       = {18'b0, r_stable};
  assign bus.press_pending_o = 1'b0;
`endif

endmodule

// File: doc/gpio_in_conditioner.md
GPIO_IN_CONDITIONER -- requirements
Module: gpio_in_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 50000, clock cycles per debounce sample tick (1 ms at 50 MHz); legal range >=1.
REQ-002 Parameter DEBOUNCE_TICKS, default 10, consecutive differing ticks required to accept a new level; legal range >=1.
REQ-003 CLK_50  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 key_i  input  4  raw board pushbuttons, asynchronous, active-low (pressed = 0).
REQ-006 sw_i  input  10  raw board slide switches, asynchronous.
REQ-007 flag_clr_i  input  4  synchronous write-one-to-clear for the press flags, one bit per key.
REQ-008 gpio_in_o  output  32  conditioned word driven into the PIO input port.
REQ-009 press_pending_o  output  1  OR of all press flags.

Function
REQ-010 Each key_i/sw_i bit SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be high for exactly one cycle when the count equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-012 First tick SHALL occur on the TICK_DIV-th rising edge after reset_n deasserts.
REQ-013 Each of the 14 bits SHALL own a stable register and a counter sized ceil(log2(DEBOUNCE_TICKS+1)) bits.
REQ-014 On a tick where synchronized sample equals stable: counter <= 0.
REQ-015 On a tick where sample differs and counter < DEBOUNCE_TICKS-1: counter <= counter+1.
REQ-016 On a tick where sample differs and counter == DEBOUNCE_TICKS-1: stable <= sample, counter <= 0; the counter SHALL never exceed DEBOUNCE_TICKS-1.
REQ-017 Between ticks, counters and stable registers SHALL hold; a glitch shorter than one tick period that is not sampled SHALL have no effect.
REQ-018 gpio_in_o[3:0] SHALL equal stable key bits, [13:4] stable switch bits (sw_i[0] at bit 4), [31:18] SHALL be constant 0; all are register outputs, no combinational path from any input.
REQ-019 Press event for key k SHALL be the clock edge on which stable key bit k changes 1->0; release (0->1) SHALL not be an event.
REQ-020 Press flag k SHALL set on the same edge as its press event and hold until cleared.
REQ-021 flag_clr_i[k]=1 SHALL clear flag k on the next edge; if press event and clear coincide for the same bit, set SHALL win (flag stays 1).
REQ-022 Clear of one bit SHALL not affect other flags; clearing an already-clear flag is a no-op.
REQ-023 press_pending_o SHALL be the registered OR of the four flags, updating on the same edge as the flags.

Reset
REQ-024 While reset_n=0: key synchronizer and stable key bits = 1, switch synchronizer and stable switch bits = 0, all counters = 0, tick counter = 0, flags = 0.
REQ-025 Reset values give gpio_in_o = 32'h0000000F, press_pending_o = 0.
REQ-026 Reset asserted mid-debounce SHALL discard partial counts; after release, a held key SHALL re-qualify over a full DEBOUNCE_TICKS window.

Configuration
REQ-027 Macro GPIO_IN_CONDITIONER_EDGE_CAPTURE_EN defined: press flags implemented, gpio_in_o[17:14] = flags[3:0], press_pending_o per REQ-023.
REQ-028 Macro undefined: no flag registers built, gpio_in_o[17:14] = 0, press_pending_o = 0, flag_clr_i ignored; REQ-010..REQ-018 unchanged.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, macro defined unless stated)
REQ-029 Reset, all inputs idle (key_i=4'hF, sw_i=0) -> gpio_in_o=32'h0000000F, press_pending_o=0 for 100 cycles.
REQ-030 sw_i=10'h3FF held -> gpio_in_o[13:4]=10'h3FF after the 3rd differing tick, not before; ticks at cycles 4, 8, 12 after sync.
REQ-031 key_i[0] bounces 0/1 each tick for 20 ticks then held 0 -> bit 0 changes only after 3 consecutive low ticks; gpio_in_o[14]=1, press_pending_o=1.
REQ-032 flag_clr_i=4'h1 pulse on the same edge as a key_i[0] press qualification -> flag 0 remains 1; separate pulse afterwards -> flag 0 = 0, press_pending_o=0.
REQ-033 reset_n pulsed low after 2 differing ticks on key_i[1] -> outputs return to REQ-025 values; key still low -> bit 1 falls only after 3 further ticks.
REQ-034 Macro undefined, key_i[2] press -> gpio_in_o[2]=0, gpio_in_o[17:14]=0, press_pending_o=0.
